alu_cmd_ctrl: RTL

- Command-side controller for the ALU: assembles a 4-byte command frame from the UART receiver, issues one ALU operation, captures the 16-bit result and streams it back to the UART transmitter as two bytes, low byte first.
- Sits between uart_rx/uart_tx and the ALU.
- Drives the ALU's Enable/AluFun/OpA/OpB inputs and consumes its AluOut/OutValid outputs.

---
 rtl/alu_cmd_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: collects a 4-byte UART frame (header, A, B, function),
// issues one ALU operation and returns the 16-bit result as two bytes, low byte first.
module alu_cmd_ctrl #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ALU_OP  = 4,
  parameter logic [DATA_W-1:0] CMD_HDR = 8'hCC,
  parameter int unsigned       TIMEOUT = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [DATA_W-1:0]   RxData,
  input  logic                RxValid,
  output logic                AluEnable,
  output logic [ALU_OP-1:0]   AluFun,
  output logic [DATA_W-1:0]   AluOpA,
  output logic [DATA_W-1:0]   AluOpB,
  input  logic [2*DATA_W-1:0] AluOut,
  input  logic                AluOutValid,
  output logic [DATA_W-1:0]   TxData,
  output logic                TxValid,
  input  logic                TxReady,
  output logic                Busy,
  output logic                Error
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle, StGetA, StGetB, StGetFun, StAluEn, StAluWait, StTxLo, StTxHi
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   res_hi_q, res_hi_d;
  logic [ALU_OP-1:0]   fun_q, fun_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                alu_en_q, alu_en_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_hi_d   = res_hi_q;
    fun_d      = fun_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    error_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (RxValid && (RxData == CMD_HDR)) state_d = StGetA;
      end
      StGetA: begin
        if (RxValid) begin
          opa_d   = RxData;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (RxValid) begin
          opb_d   = RxData;
          state_d = StGetFun;
        end
      end
      StGetFun: begin
        if (RxValid) begin
          fun_d   = RxData[ALU_OP-1:0];
          state_d = StAluEn;
        end
      end
      StAluEn: begin
        cnt_d   = '0;
        state_d = StAluWait;
      end
      StAluWait: begin
        if (AluOutValid) begin
          res_hi_d   = AluOut[2*DATA_W-1:DATA_W];
          tx_data_d  = AluOut[DATA_W-1:0];
          tx_valid_d = 1'b1;
          state_d    = StTxLo;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          // Registered Error then lands exactly TIMEOUT cycles after AluEnable.
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StTxLo: begin
        if (tx_valid_q && TxReady) begin
          tx_data_d = res_hi_q;
          state_d   = StTxHi;
        end
      end
      StTxHi: begin
        if (tx_valid_q && TxReady) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    alu_en_d = (state_d == StAluEn);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      res_hi_q   <= '0;
      fun_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      alu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_hi_q   <= res_hi_d;
      fun_q      <= fun_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      alu_en_q   <= alu_en_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign AluEnable = alu_en_q;
  assign AluFun    = fun_q;
  assign AluOpA    = opa_q;
  assign AluOpB    = opb_q;
  assign TxData    = tx_data_q;
  assign TxValid   = tx_valid_q;
  assign Busy      = busy_q;
  assign Error     = error_q;

endmodule
